// File: rtl/cordic_pkg.sv
// Shared constants for the iterative CORDIC: arctangent table, FSM encoding and mode values.
package cordic_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    // atan(2^-i) scaled so that 2^31 represents pi, rounded to nearest.
    function automatic logic [31:0] atan_entry(input logic [4:0] idx);
        logic [31:0] v;
        case (idx)
            5'd0:  v = 32'd536870912;
            5'd1:  v = 32'd316933406;
            5'd2:  v = 32'd167458907;
            5'd3:  v = 32'd85004756;
            5'd4:  v = 32'd42667331;
            5'd5:  v = 32'd21354465;
            5'd6:  v = 32'd10679838;
            5'd7:  v = 32'd5340245;
            5'd8:  v = 32'd2670163;
            5'd9:  v = 32'd1335087;
            5'd10: v = 32'd667544;
            5'd11: v = 32'd333772;
            5'd12: v = 32'd166886;
            5'd13: v = 32'd83443;
            5'd14: v = 32'd41722;
            5'd15: v = 32'd20861;
            5'd16: v = 32'd10430;
            5'd17: v = 32'd5215;
            5'd18: v = 32'd2608;
            5'd19: v = 32'd1304;
            5'd20: v = 32'd652;
            5'd21: v = 32'd326;
            5'd22: v = 32'd163;
            5'd23: v = 32'd81;
            5'd24: v = 32'd41;
            5'd25: v = 32'd20;
            5'd26: v = 32'd10;
            5'd27: v = 32'd5;
            5'd28: v = 32'd3;
            5'd29: v = 32'd1;
            5'd30: v = 32'd1;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cordic_iter_shift.sv
// N-bit arithmetic right shifter with a 5-bit shift amount.
module shift #(
    parameter int N = 16
) (
    input  logic signed [N-1:0] value,
    input  logic        [4:0]   amount,
    output logic signed [N-1:0] result
);

    assign result = value >>> amount;

endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC, one micro-rotation per clock, rotation or vectoring mode, no gain compensation.
module cordic_iter
    import cordic_pkg::*;
#(
    parameter int N    = 16,
    parameter int ITER = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mode,
    input  logic signed [N-1:0] x_in,
    input  logic signed [N-1:0] y_in,
    input  logic signed [N-1:0] z_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] x_out,
    output logic signed [N-1:0] y_out,
    output logic signed [N-1:0] z_out
);

    localparam int CW = (ITER <= 1) ? 1 : $clog2(ITER);

    // Table entry re-scaled from the 32-bit angle format to N bits (floor shift).
    function automatic logic signed [N-1:0] atan_scaled(input logic [4:0] idx);
        logic signed [31:0] t;
        t = signed'(atan_entry(idx)) >>> (32 - N);
        return t[N-1:0];
    endfunction

    logic [1:0]          state;
    logic [CW-1:0]       iter_cnt;
    logic                mode_r;
    logic signed [N-1:0] x_r, y_r, z_r;

    logic [4:0]          shift_amt;
    logic signed [N-1:0] x_sh, y_sh, atan_i;
    logic signed [N-1:0] x_nxt, y_nxt, z_nxt;
    logic                dir_pos;
    logic                accept, last_iter;

    assign accept    = in_valid && in_ready;
    assign last_iter = (iter_cnt == CW'(ITER - 1));
    assign shift_amt = 5'(iter_cnt);
    assign atan_i    = atan_scaled(shift_amt);

    shift #(.N(N)) u_shift_x (.value(x_r), .amount(shift_amt), .result(x_sh));
    shift #(.N(N)) u_shift_y (.value(y_r), .amount(shift_amt), .result(y_sh));

    // Rotation drives z toward zero; vectoring drives y toward zero.
    always_comb begin
        dir_pos = (mode_r == MODE_ROT) ? ~z_r[N-1] : y_r[N-1];
        if (dir_pos) begin
            x_nxt = x_r - y_sh;
            y_nxt = y_r + x_sh;
            z_nxt = z_r - atan_i;
        end else begin
            x_nxt = x_r + y_sh;
            y_nxt = y_r - x_sh;
            z_nxt = z_r + atan_i;
        end
    end

    // Working registers: loaded on accept, stepped every RUN cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            x_r    <= x_in;
            y_r    <= y_in;
            z_r    <= z_in;
            mode_r <= mode;
        end else if (state == ST_RUN) begin
            x_r <= x_nxt;
            y_r <= y_nxt;
            z_r <= z_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            iter_cnt  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_RUN;
                        iter_cnt <= '0;
                        in_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (last_iter) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        x_out     <= x_nxt;
                        y_out     <= y_nxt;
                        z_out     <= z_nxt;
                    end else begin
                        iter_cnt <= iter_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_iter.sv
// Directed self-checking bench for cordic_iter (N = 16, ITER = 14).
module tb_cordic_iter;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic               mode;
    logic signed [15:0] x_in, y_in, z_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] x_out, y_out, z_out;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    cordic_iter #(.N(16), .ITER(14)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .z_out(z_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Issue one operation and wait for its result; caller sits on a falling edge.
    task automatic do_op(input int xv, input int yv, input int zv, input logic m,
                         output int rx, output int ry, output int rz,
                         output int acc_cyc, output int done_cyc, output bit timeout);
        int n;
        timeout = 1'b0;
        in_valid = 1'b1;
        x_in = 16'(xv); y_in = 16'(yv); z_in = 16'(zv); mode = m;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout = 1'b1;
        @(negedge clk);
        acc_cyc = cyc;
        in_valid = 1'b0;
        x_in = '0; y_in = '0; z_in = '0; mode = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout = 1'b1;
        done_cyc = cyc;
        rx = int'(x_out); ry = int'(y_out); rz = int'(z_out);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b1;
        x_in = '0; y_in = '0; z_in = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if ({x_out, y_out, z_out} !== 48'd0) begin n_fail++; $display("FAIL reset_outputs got %0d %0d %0d want 0 0 0", x_out, y_out, z_out); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_rotation;
        int rx, ry, rz, a, d; bit to;
        do_op(8192, 0, 8192, 1'b0, rx, ry, rz, a, d, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL rot_pi4_timeout no result within bound"); end
        n_checks++;
        if (rx - 9540 > 4 || 9540 - rx > 4) begin n_fail++; $display("FAIL rot_pi4_x got %0d want 9540+/-4", rx); end
        n_checks++;
        if (ry - 9540 > 4 || 9540 - ry > 4) begin n_fail++; $display("FAIL rot_pi4_y got %0d want 9540+/-4", ry); end
        n_checks++;
        if (rz > 4 || rz < -4) begin n_fail++; $display("FAIL rot_pi4_z got %0d want 0+/-4", rz); end
    endtask

    task automatic test_vectoring;
        int rx, ry, rz, a, d; bit to;
        do_op(8192, 8192, 0, 1'b1, rx, ry, rz, a, d, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL vec_timeout no result within bound"); end
        n_checks++;
        if (rx - 19079 > 4 || 19079 - rx > 4) begin n_fail++; $display("FAIL vec_x got %0d want 19079+/-4", rx); end
        n_checks++;
        if (ry > 4 || ry < -4) begin n_fail++; $display("FAIL vec_y got %0d want 0+/-4", ry); end
        n_checks++;
        if (rz - 8192 > 4 || 8192 - rz > 4) begin n_fail++; $display("FAIL vec_z got %0d want 8192+/-4", rz); end
    endtask

    task automatic test_rot_zero_and_latency;
        int rx, ry, rz, a, d; bit to;
        do_op(8192, 0, 0, 1'b0, rx, ry, rz, a, d, to);
        n_checks++;
        if (rx - 13491 > 4 || 13491 - rx > 4) begin n_fail++; $display("FAIL rot_z0_x got %0d want 13491+/-4", rx); end
        n_checks++;
        if (ry > 4 || ry < -4) begin n_fail++; $display("FAIL rot_z0_y got %0d want 0+/-4", ry); end
        n_checks++;
        if (to || (d - a) != 14) begin n_fail++; $display("FAIL latency got %0d edges want 14 (timeout=%0d)", d - a, to); end
    endtask

    task automatic test_back_to_back;
        int acc[2];
        int na, n;
        na = 0;
        in_valid = 1'b1; mode = 1'b0;
        x_in = 16'sd4096; y_in = 16'sd0; z_in = 16'sd0;
        for (int k = 0; k < 80 && na < 2; k++) begin
            if (in_ready) begin acc[na] = cyc + 1; na++; end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (na != 2) begin n_fail++; $display("FAIL b2b_accepts got %0d want 2", na); end
        else begin
            n_checks++;
            if (acc[1] - acc[0] != 16) begin n_fail++; $display("FAIL b2b_spacing got %0d want 16", acc[1] - acc[0]); end
        end
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int rx, ry, rz, a, d; bit to;
        bit stable, ready_low, valid_hi;
        out_ready = 1'b0;
        do_op(8192, 0, 0, 1'b0, rx, ry, rz, a, d, to);
        in_valid = 1'b1; mode = 1'b1;
        x_in = 16'sd1000; y_in = 16'sd2000; z_in = 16'sd3000;
        stable = 1'b1; ready_low = 1'b1; valid_hi = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (int'(x_out) != rx || int'(y_out) != ry || int'(z_out) != rz) stable = 1'b0;
            if (in_ready !== 1'b0) ready_low = 1'b0;
            if (out_valid !== 1'b1) valid_hi = 1'b0;
        end
        n_checks++;
        if (to || !valid_hi) begin n_fail++; $display("FAIL bp_out_valid got held=%0d want 1 (timeout=%0d)", valid_hi, to); end
        n_checks++;
        if (!stable) begin n_fail++; $display("FAIL bp_outputs_stable got %0d %0d %0d want %0d %0d %0d", x_out, y_out, z_out, rx, ry, rz); end
        n_checks++;
        if (!ready_low) begin n_fail++; $display("FAIL bp_in_ready got 1 want 0"); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        n_checks++;
        if (rx - 13491 > 4 || 13491 - rx > 4) begin n_fail++; $display("FAIL bp_result_x got %0d want 13491+/-4", rx); end
    endtask

    task automatic test_reset_mid_run;
        int rx, ry, rz, a, d, k0, n; bit to;
        in_valid = 1'b1; mode = 1'b0;
        x_in = 16'sd8192; y_in = 16'sd0; z_in = 16'sd8192;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        k0 = cyc;
        in_valid = 1'b0;
        while (cyc < k0 + 6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_run_out_valid got %b want 0", out_valid); end
        n_checks++;
        if ({x_out, y_out, z_out} !== 48'd0) begin n_fail++; $display("FAIL rst_run_outputs got %0d %0d %0d want 0 0 0", x_out, y_out, z_out); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_run_in_ready got %b want 1", in_ready); end
        do_op(8192, 8192, 0, 1'b1, rx, ry, rz, a, d, to);
        n_checks++;
        if (to || (d - a) != 14) begin n_fail++; $display("FAIL rst_run_fresh_latency got %0d want 14 (timeout=%0d)", d - a, to); end
        n_checks++;
        if (rx - 19079 > 4 || 19079 - rx > 4) begin n_fail++; $display("FAIL rst_run_fresh_x got %0d want 19079+/-4", rx); end
        n_checks++;
        if (rz - 8192 > 4 || 8192 - rz > 4) begin n_fail++; $display("FAIL rst_run_fresh_z got %0d want 8192+/-4", rz); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_vectoring();
        test_rot_zero_and_latency();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
